serial_deser: RTL and testbench

Frame deserializer that sits directly downstream of the D flip-flop input stage. It samples the registered serial line (the flop's Q) on qualified bit strobes and detects start bits. It assembles fixed-width LSB-first words and presents each completed word on a valid/ready output with overrun and framing-error reporting. It converts the single-bit registered stream into parallel words for the consumer logic.

---
 rtl/serial_deser_pkg.sv | 23 ++
 rtl/serial_deser_shift_reg.sv | 45 ++++
 rtl/serial_deser.sv | 146 ++++++++++++++
 tb/tb_serial_deser.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_deser_pkg.sv
// Shared types and constants for the serial_deser frame deserializer.
package serial_deser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width; never below 1 so the counter always exists.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_deser_shift_reg.sv
// LSB-first shift register for serial_deser with a running XOR of the shifted-in bits.
module deser_shift_reg
    import serial_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] data,
    output logic             parity
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             par_q, par_d;

    // New bits enter at the MSB so the first bit received ends up in bit 0.
    always_comb begin
        data_d = data_q;
        par_d  = par_q;
        if (clr) begin
            data_d = '0;
            par_d  = 1'b0;
        end else if (shift_en) begin
            data_d = {bit_in, data_q[WIDTH-1:1]};
            par_d  = par_q ^ bit_in;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            data_q <= '0;
            par_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            par_q  <= par_d;
        end
    end

    assign data   = data_q;
    assign parity = par_q;

endmodule

// File: rtl/serial_deser.sv
// Frame deserializer: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Optional parity bit and PERR port are enabled by defining SERIAL_DESER_PARITY_EN.
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SER_IN,
    input  logic             BIT_EN,
    output logic [WIDTH-1:0] DOUT,
    output logic             DVALID,
    input  logic             DREADY,
    output logic             OVERRUN,
`ifdef SERIAL_DESER_PARITY_EN
    output logic             PERR,
`endif
    output logic             FERR
);

    localparam int             CW   = clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             overrun_q, overrun_d;
    logic             ferr_q, ferr_d;
    logic             perr_q, perr_d;

    logic             sr_clr, sr_shift, word_done;
    logic [WIDTH-1:0] sr_data;
    logic             sr_par;

    deser_shift_reg #(.WIDTH(WIDTH)) u_shift (
        .clk      (CLK),
        .srst     (RST),
        .clr      (sr_clr),
        .shift_en (sr_shift),
        .bit_in   (SER_IN),
        .data     (sr_data),
        .parity   (sr_par)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        dvalid_d  = dvalid_q;
        overrun_d = overrun_q;
        ferr_d    = ferr_q;
        perr_d    = perr_q;
        sr_clr    = 1'b0;
        sr_shift  = 1'b0;
        word_done = 1'b0;

        if (dvalid_q && DREADY) begin
            dvalid_d = 1'b0;
        end

        if (BIT_EN) begin
            case (state_q)
                IDLE: begin
                    if (!SER_IN) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        sr_clr  = 1'b1;
                    end
                end
                DATA: begin
                    sr_shift = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
`ifdef SERIAL_DESER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
`ifdef SERIAL_DESER_PARITY_EN
                PARITY: begin
                    if (SER_IN != sr_par) begin
                        perr_d = 1'b1;
                    end
                    state_d = STOP;
                end
`endif
                STOP: begin
                    // A low stop bit is a framing error, never a fresh start bit.
                    if (SER_IN) begin
                        word_done = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (word_done) begin
            if (!dvalid_q || DREADY) begin
                dout_d   = sr_data;
                dvalid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dout_q    <= '0;
            dvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            dvalid_q  <= dvalid_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
        end
    end

    assign DOUT    = dout_q;
    assign DVALID  = dvalid_q;
    assign OVERRUN = overrun_q;
    assign FERR    = ferr_q;
`ifdef SERIAL_DESER_PARITY_EN
    assign PERR    = perr_q;
`else
    logic unused_parity;
    assign unused_parity = sr_par ^ perr_q;
`endif

endmodule

// File: tb/tb_serial_deser.sv
// Directed self-checking bench for serial_deser (WIDTH=8); parity cases under SERIAL_DESER_PARITY_EN.
module tb_serial_deser;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ser_in = 1'b1;
    logic         bit_en = 1'b0;
    logic         dready = 1'b0;
    logic [W-1:0] dout;
    logic         dvalid;
    logic         overrun;
    logic         ferr;
`ifdef SERIAL_DESER_PARITY_EN
    logic         perr;
`endif

    int cmp_count = 0;
    int err_count = 0;

    always #5 clk = ~clk;

    serial_deser #(.WIDTH(W)) dut (
        .CLK     (clk),
        .RST     (rst),
        .SER_IN  (ser_in),
        .BIT_EN  (bit_en),
        .DOUT    (dout),
        .DVALID  (dvalid),
        .DREADY  (dready),
        .OVERRUN (overrun),
`ifdef SERIAL_DESER_PARITY_EN
        .PERR    (perr),
`endif
        .FERR    (ferr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobed bit; the strobe edge is followed by gap-1 idle cycles.
    task automatic send_bit(input logic b, input int gap);
        ser_in = b;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        ser_in = 1'b1;
        for (int i = 1; i < gap; i++) tick();
    endtask

    // Full frame; DREADY is raised only for the stop-bit edge when ready_at_stop is set.
    task automatic send_frame(input logic [W-1:0] data, input logic par_bit, input logic stop_bit,
                              input int gap, input logic ready_at_stop);
        send_bit(1'b0, gap);
        for (int i = 0; i < W; i++) send_bit(data[i], gap);
`ifdef SERIAL_DESER_PARITY_EN
        send_bit(par_bit, gap);
`endif
        if (ready_at_stop) dready = 1'b1;
        ser_in = stop_bit;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        ser_in = 1'b1;
        dready = 1'b0;
        $display("frame data=%02h par=%0b stop=%0b -> dout=%02h dvalid=%0b ovr=%0b ferr=%0b",
                 data, par_bit, stop_bit, dout, dvalid, overrun, ferr);
        for (int i = 1; i < gap; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic consume();
        dready = 1'b1;
        tick();
        dready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ser_in = i[0];
            bit_en = 1'b1;
            tick();
        end
        cmp_count++;
        if (dout !== 8'h00) begin err_count++; $display("FAIL reset_dout got=%02h exp=00", dout); end
        cmp_count++;
        if ({dvalid, overrun, ferr} !== 3'b000) begin
            err_count++; $display("FAIL reset_flags got=%03b exp=000", {dvalid, overrun, ferr});
        end
        rst = 1'b0;
        ser_in = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bit_en = 1'b0;
        dready = 1'b0;
        cmp_count++;
        if (dvalid !== 1'b0) begin err_count++; $display("FAIL reset_idle_dvalid got=%0b exp=0", dvalid); end
    endtask

    task automatic test_single_frame();
        do_reset();
        send_bit(1'b0, 4);
        for (int i = 0; i < W; i++) send_bit(logic'((8'hA5 >> i) & 1), 4);
`ifdef SERIAL_DESER_PARITY_EN
        send_bit(1'b0, 4);
`endif
        cmp_count++;
        if (dvalid !== 1'b0) begin err_count++; $display("FAIL single_pre_stop_dvalid got=%0b exp=0", dvalid); end
        ser_in = 1'b1;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        $display("frame data=a5 stop=1 -> dout=%02h dvalid=%0b", dout, dvalid);
        cmp_count++;
        if (dvalid !== 1'b1) begin err_count++; $display("FAIL single_dvalid got=%0b exp=1", dvalid); end
        cmp_count++;
        if (dout !== 8'hA5) begin err_count++; $display("FAIL single_dout got=%02h exp=a5", dout); end
        cmp_count++;
        if (ferr !== 1'b0) begin err_count++; $display("FAIL single_ferr got=%0b exp=0", ferr); end
        consume();
        cmp_count++;
        if (dvalid !== 1'b0) begin err_count++; $display("FAIL consume_dvalid got=%0b exp=0", dvalid); end
        cmp_count++;
        if (dout !== 8'hA5) begin err_count++; $display("FAIL consume_dout_hold got=%02h exp=a5", dout); end
    endtask

    task automatic test_handshake();
        do_reset();
        send_frame(8'h3C, 1'b0, 1'b1, 2, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, 2, 1'b0);
        cmp_count++;
        if (dout !== 8'h3C) begin err_count++; $display("FAIL overrun_dout got=%02h exp=3c", dout); end
        cmp_count++;
        if (overrun !== 1'b1) begin err_count++; $display("FAIL overrun_flag got=%0b exp=1", overrun); end
        cmp_count++;
        if (dvalid !== 1'b1) begin err_count++; $display("FAIL overrun_dvalid got=%0b exp=1", dvalid); end

        do_reset();
        send_frame(8'h3C, 1'b0, 1'b1, 2, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, 2, 1'b1);
        cmp_count++;
        if (dout !== 8'h81) begin err_count++; $display("FAIL replace_dout got=%02h exp=81", dout); end
        cmp_count++;
        if (dvalid !== 1'b1) begin err_count++; $display("FAIL replace_dvalid got=%0b exp=1", dvalid); end
        cmp_count++;
        if (overrun !== 1'b0) begin err_count++; $display("FAIL replace_overrun got=%0b exp=0", overrun); end
    endtask

    task automatic test_framing();
        do_reset();
        send_frame(8'h55, 1'b0, 1'b0, 3, 1'b0);
        cmp_count++;
        if (ferr !== 1'b1) begin err_count++; $display("FAIL ferr_flag got=%0b exp=1", ferr); end
        cmp_count++;
        if (dvalid !== 1'b0) begin err_count++; $display("FAIL ferr_dvalid got=%0b exp=0", dvalid); end
        send_frame(8'h12, 1'b0, 1'b1, 3, 1'b0);
        cmp_count++;
        if (dout !== 8'h12) begin err_count++; $display("FAIL ferr_next_dout got=%02h exp=12", dout); end
        cmp_count++;
        if (ferr !== 1'b1) begin err_count++; $display("FAIL ferr_sticky got=%0b exp=1", ferr); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_bit(1'b0, 1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
        do_reset();
        send_frame(8'hF0, 1'b0, 1'b1, 2, 1'b0);
        cmp_count++;
        if (dout !== 8'hF0) begin err_count++; $display("FAIL midrst_dout got=%02h exp=f0", dout); end
        cmp_count++;
        if ({overrun, ferr} !== 2'b00) begin
            err_count++; $display("FAIL midrst_flags got=%02b exp=00", {overrun, ferr});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_frame(8'h5A, 1'b0, 1'b1, 1, 1'b0);
        cmp_count++;
        if (dout !== 8'h5A) begin err_count++; $display("FAIL b2b_first_dout got=%02h exp=5a", dout); end
        consume();
        send_frame(8'hC3, 1'b0, 1'b1, 1, 1'b0);
        cmp_count++;
        if (dout !== 8'hC3) begin err_count++; $display("FAIL b2b_second_dout got=%02h exp=c3", dout); end
        cmp_count++;
        if ({dvalid, overrun, ferr} !== 3'b100) begin
            err_count++; $display("FAIL b2b_flags got=%03b exp=100", {dvalid, overrun, ferr});
        end
    endtask

`ifdef SERIAL_DESER_PARITY_EN
    task automatic test_parity();
        do_reset();
        send_frame(8'h07, 1'b1, 1'b1, 2, 1'b0);
        cmp_count++;
        if (perr !== 1'b0) begin err_count++; $display("FAIL parity_good_perr got=%0b exp=0", perr); end
        consume();
        send_frame(8'h07, 1'b0, 1'b1, 2, 1'b0);
        cmp_count++;
        if (perr !== 1'b1) begin err_count++; $display("FAIL parity_bad_perr got=%0b exp=1", perr); end
        cmp_count++;
        if ({dvalid, dout} !== {1'b1, 8'h07}) begin
            err_count++; $display("FAIL parity_bad_word got=%0b/%02h exp=1/07", dvalid, dout);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_handshake();
        test_framing();
        test_mid_reset();
        test_back_to_back();
`ifdef SERIAL_DESER_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
